// File: rtl/bsg_two_fifo_mem_ctrl_if.sv
// Handshake and memory-port bundle for bsg_two_fifo_mem_ctrl.
// The slave modport is the FIFO controller's view.
// The master modport is the view of the surrounding producer, consumer and memory.
interface bsg_two_fifo_mem_ctrl_if #(
    parameter int width_p = 58
);
    logic               v_i;
    logic [width_p-1:0] data_i;
    logic               ready_o;
    logic               v_o;
    logic [width_p-1:0] data_o;
    logic               yumi_i;
    logic [1:0]         count_o;
    logic               mem_w_v_o;
    logic               mem_w_addr_o;
    logic [width_p-1:0] mem_w_data_o;
    logic               mem_r_v_o;
    logic               mem_r_addr_o;
    logic [width_p-1:0] mem_r_data_i;

    modport slave (
        input  v_i, data_i, yumi_i, mem_r_data_i,
        output ready_o, v_o, data_o, count_o,
        output mem_w_v_o, mem_w_addr_o, mem_w_data_o, mem_r_v_o, mem_r_addr_o
    );

    modport master (
        output v_i, data_i, yumi_i, mem_r_data_i,
        input  ready_o, v_o, data_o, count_o,
        input  mem_w_v_o, mem_w_addr_o, mem_w_data_o, mem_r_v_o, mem_r_addr_o
    );
endinterface

// File: rtl/bsg_two_fifo_mem_ctrl.sv
// Two-entry FIFO controller that sequences a sibling 2-word 1r1w memory.
// The controller owns the head and tail pointers, the occupancy count and both handshakes.
// The producer side uses valid/ready and the consumer side uses valid/yumi.
// The optional macro BSG_TWO_FIFO_MEM_CTRL_BYPASS_EN adds a zero-latency path from data_i to data_o while the FIFO is empty.
// Without that macro, data always reaches data_o one cycle after it is enqueued.
module bsg_two_fifo_mem_ctrl #(
    parameter int width_p = 58
) (
    input logic                    clk_i,
    input logic                    reset_n_i,
    bsg_two_fifo_mem_ctrl_if.slave bus
);

    logic               r_wptr;
    logic               r_rptr;
    logic [1:0]         r_count;
    logic               r_initDone;

    logic               w_empty;
    logic               w_full;
    logic               w_ready;
    logic               w_vOut;
    logic [width_p-1:0] w_dataOut;
    logic               w_bypassTake;
    logic               w_memRead;
    logic               w_enq;
    logic               w_deq;

    // Decode the handshakes from the occupancy and decide which side feeds data_o.
    // Writes target the tail and reads target the head.
    // A full FIFO refuses input, so a write can never land on the slot being read.
    always_comb begin
        w_empty      = (r_count == 2'd0);
        w_full       = (r_count == 2'd2);
        w_ready      = r_initDone & ~w_full;
`ifdef BSG_TWO_FIFO_MEM_CTRL_BYPASS_EN
        w_vOut       = w_empty ? (r_initDone & bus.v_i) : 1'b1;
        w_dataOut    = w_empty ? bus.data_i : bus.mem_r_data_i;
        w_bypassTake = w_empty & w_vOut & bus.yumi_i;
        w_memRead    = ~w_empty;
`else
        w_vOut       = ~w_empty;
        w_dataOut    = bus.mem_r_data_i;
        w_bypassTake = 1'b0;
        w_memRead    = ~w_empty;
`endif
        w_enq        = bus.v_i & w_ready & ~w_bypassTake;
        w_deq        = bus.yumi_i & w_vOut & ~w_empty;
    end

    // Advance the pointers and the count on each transfer.
    // The init flag holds ready low for one cycle after reset is released.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_count    <= 2'd0;
            r_initDone <= 1'b0;
        end else begin
            r_initDone <= 1'b1;
            if (w_enq) begin
                r_wptr <= ~r_wptr;
            end
            if (w_deq) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
        end
    end

    assign bus.ready_o      = w_ready;
    assign bus.v_o          = w_vOut;
    assign bus.data_o       = w_dataOut;
    assign bus.count_o      = r_count;
    assign bus.mem_w_v_o    = w_enq;
    assign bus.mem_w_addr_o = r_wptr;
    assign bus.mem_w_data_o = bus.data_i;
    assign bus.mem_r_v_o    = w_memRead;
    assign bus.mem_r_addr_o = r_rptr;

endmodule

// File: tb/tb_bsg_two_fifo_mem_ctrl.sv
// Self-checking bench for bsg_two_fifo_mem_ctrl.
// It uses a directed vector table, hand-written streaming and bypass sequences, and random traffic.
// Random traffic is checked against a queue-based reference model.
// A 2-word memory model sits on the mem_* ports.
// The bypass checks follow BSG_TWO_FIFO_MEM_CTRL_BYPASS_EN.
module tb_bsg_two_fifo_mem_ctrl;

    localparam int W = 58;
`ifdef BSG_TWO_FIFO_MEM_CTRL_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        bit         rstN;
        bit         v;
        logic [W-1:0] data;
        bit         yumi;
        bit         expReady;
        bit         expV;
        logic [W-1:0] expData;
        logic [1:0] expCount;
        bit         expWv;
        bit         expWaddr;
        bit         expRv;
        bit         expRaddr;
    } vec_t;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    bsg_two_fifo_mem_ctrl_if #(.width_p(W)) bus ();

    bsg_two_fifo_mem_ctrl #(.width_p(W)) dut (
        .clk_i     (clk),
        .reset_n_i (rstN),
        .bus       (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Sibling memory: write on posedge, combinational read
    logic [W-1:0] memArr [2];
    always @(posedge clk) begin
        if (bus.mem_w_v_o) memArr[bus.mem_w_addr_o] <= bus.mem_w_data_o;
    end
    assign bus.mem_r_data_i = memArr[bus.mem_r_addr_o];

    // Reference model: contents as a queue, pointers as transfer counts
    logic [W-1:0] refQ [$];
    bit           refInit = 1'b0;
    int           wrCount = 0;
    int           rdCount = 0;
    bit           curV, curY;
    logic [W-1:0] curData;
    bit           eReady, eV, eWv, eWaddr, eRv, eRaddr, eEnq, eDeq;
    logic [W-1:0] eData;
    logic [1:0]   eCount;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit v, input logic [W-1:0] d, input bit y);
        @(negedge clk);
        rstN        = r;
        bus.v_i     = v;
        bus.data_i  = d;
        bus.yumi_i  = y;
        curV        = v;
        curData     = d;
        curY        = y;
        #2;
    endtask

    task automatic computeModel();
        int sz;
        bit byp;
        bit bypTake;
        sz      = refQ.size();
        byp     = BYPASS && (sz == 0);
        eReady  = refInit && (sz < 2);
        eV      = byp ? (refInit && curV) : (sz != 0);
        eData   = byp ? curData : ((sz != 0) ? refQ[0] : '0);
        bypTake = byp && eV && curY;
        eEnq    = curV && eReady && !bypTake;
        eDeq    = curY && (sz != 0);
        eWv     = eEnq;
        eWaddr  = wrCount[0];
        eRv     = (sz != 0);
        eRaddr  = rdCount[0];
        eCount  = 2'(sz);
    endtask

    task automatic updateModel(input bit r);
        if (!r) begin
            refQ.delete();
            refInit = 1'b0;
            wrCount = 0;
            rdCount = 0;
        end else begin
            if (eDeq) begin
                void'(refQ.pop_front());
                rdCount++;
            end
            if (eEnq) begin
                refQ.push_back(curData);
                wrCount++;
            end
            refInit = 1'b1;
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "_ready"}, 64'(bus.ready_o), 64'(eReady));
        checkOutput({tag, "_v"}, 64'(bus.v_o), 64'(eV));
        if (eV) checkOutput({tag, "_data"}, 64'(bus.data_o), 64'(eData));
        checkOutput({tag, "_count"}, 64'(bus.count_o), 64'(eCount));
        checkOutput({tag, "_wv"}, 64'(bus.mem_w_v_o), 64'(eWv));
        checkOutput({tag, "_waddr"}, 64'(bus.mem_w_addr_o), 64'(eWaddr));
        if (eWv) checkOutput({tag, "_wdata"}, 64'(bus.mem_w_data_o), 64'(curData));
        checkOutput({tag, "_rv"}, 64'(bus.mem_r_v_o), 64'(eRv));
        checkOutput({tag, "_raddr"}, 64'(bus.mem_r_addr_o), 64'(eRaddr));
    endtask

    // Main test sequence
    initial begin
        vec_t vecs [12];
        bus.v_i    = 1'b0;
        bus.data_i = '0;
        bus.yumi_i = 1'b0;
        curV = 1'b0; curY = 1'b0; curData = '0;
        rstN = 1'b0;
        @(posedge clk);

        vecs[0]  = '{1'b0, 1'b1, 58'h0AA, 1'b0, 1'b0, 1'b0,   58'h0,   2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 58'h0AA, 1'b0, 1'b0, 1'b0,   58'h0,   2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 58'h0AA, 1'b0, 1'b0, 1'b0,   58'h0,   2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 58'h0AA, 1'b0, 1'b0, 1'b0,   58'h0,   2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 58'h0AA, 1'b0, 1'b1, BYPASS, 58'h0AA, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 58'h155, 1'b0, 1'b1, 1'b1,   58'h0AA, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 58'h0,   1'b0, 1'b0, 1'b1,   58'h0AA, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 58'h0,   1'b1, 1'b0, 1'b1,   58'h0AA, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 58'h0,   1'b1, 1'b1, 1'b1,   58'h155, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 58'h0,   1'b0, 1'b1, 1'b0,   58'h0,   2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 58'h0,   1'b1, 1'b1, 1'b0,   58'h0,   2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 58'h0,   1'b0, 1'b1, 1'b0,   58'h0,   2'd0, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].rstN, vecs[i].v, vecs[i].data, vecs[i].yumi);
            computeModel();
            checkOutput($sformatf("vec%0d_ready", i), 64'(bus.ready_o), 64'(vecs[i].expReady));
            checkOutput($sformatf("vec%0d_v", i), 64'(bus.v_o), 64'(vecs[i].expV));
            if (vecs[i].expV)
                checkOutput($sformatf("vec%0d_data", i), 64'(bus.data_o), 64'(vecs[i].expData));
            checkOutput($sformatf("vec%0d_count", i), 64'(bus.count_o), 64'(vecs[i].expCount));
            checkOutput($sformatf("vec%0d_wv", i), 64'(bus.mem_w_v_o), 64'(vecs[i].expWv));
            checkOutput($sformatf("vec%0d_waddr", i), 64'(bus.mem_w_addr_o), 64'(vecs[i].expWaddr));
            checkOutput($sformatf("vec%0d_rv", i), 64'(bus.mem_r_v_o), 64'(vecs[i].expRv));
            checkOutput($sformatf("vec%0d_raddr", i), 64'(bus.mem_r_addr_o), 64'(vecs[i].expRaddr));
            updateModel(vecs[i].rstN);
        end

        applyStimulus(1'b1, 1'b1, 58'd1, 1'b0);
        computeModel();
        checkModel("preload");
        updateModel(1'b1);
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b1, 1'b1, 58'(k + 1), 1'b1);
            computeModel();
            checkOutput($sformatf("stream%0d_data", k), 64'(bus.data_o), 64'(k));
            checkOutput($sformatf("stream%0d_count", k), 64'(bus.count_o), 64'd1);
            checkOutput($sformatf("stream%0d_v", k), 64'(bus.v_o), 64'd1);
            checkOutput($sformatf("stream%0d_ready", k), 64'(bus.ready_o), 64'd1);
            updateModel(1'b1);
        end
        applyStimulus(1'b1, 1'b0, 58'd0, 1'b1);
        computeModel();
        checkOutput("drain_data", 64'(bus.data_o), 64'd11);
        checkOutput("drain_count", 64'(bus.count_o), 64'd1);
        updateModel(1'b1);
        applyStimulus(1'b1, 1'b0, 58'd0, 1'b0);
        computeModel();
        checkModel("drained");
        updateModel(1'b1);

`ifdef BSG_TWO_FIFO_MEM_CTRL_BYPASS_EN
        applyStimulus(1'b1, 1'b1, 58'h3, 1'b1);
        computeModel();
        checkOutput("bypass_v", 64'(bus.v_o), 64'd1);
        checkOutput("bypass_data", 64'(bus.data_o), 64'h3);
        checkOutput("bypass_wv", 64'(bus.mem_w_v_o), 64'd0);
        checkOutput("bypass_rv", 64'(bus.mem_r_v_o), 64'd0);
        updateModel(1'b1);
        applyStimulus(1'b1, 1'b0, 58'h0, 1'b0);
        computeModel();
        checkOutput("bypass_after_count", 64'(bus.count_o), 64'd0);
        checkModel("bypass_after");
        updateModel(1'b1);
`endif

        for (int n = 0; n < 400; n++) begin
            bit r, v, y;
            logic [W-1:0] d;
            r = ($urandom_range(0, 39) != 0);
            v = 1'($urandom_range(0, 1));
            y = ($urandom_range(0, 2) != 0);
            d = W'({$urandom, $urandom});
            applyStimulus(r, v, d, y);
            computeModel();
            if (r) checkModel($sformatf("rand%0d", n));
            updateModel(r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
